mem_io_bridge: RTL
==================

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max IO_REQ cycles waited for io_ack before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports addr  input  32 and wdata  input  32, M-stage byte address and store data.
REQ-005 SHALL have ports BeOP  input  2, store size (00 none, 01 SB, 10 SH, 11 SW), and MeOP  input  3, load size (000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW).
REQ-006 SHALL have ports MemWrite  input  1, IOWrite  input  1, and IORead  input  1, the M-stage memory store, IO store, and IO load strobes.
REQ-007 SHALL have ports rdata  output  32, extended load result, and stall  output  1, holding M stage and upstream.
REQ-008 SHALL have ports dm_we  output  1, dm_be  output  4, dm_addr  output  32 (addr with bits[1:0] zeroed), dm_wdata  output  32, and dm_rdata  input  32 (combinational read).
REQ-009 SHALL have ports io_req  output  1, io_we  output  1, io_addr  output  32, io_be  output  4, io_wdata  output  32, io_rdata  input  32, and io_ack  input  1.
REQ-010 SHALL have port err  output  1, a one-cycle pulse flagging a misaligned access or IO timeout.

Function
REQ-011 SHALL derive lane enables from BeOP and addr[1:0]: SB gives 1<<addr[1:0]; SH gives 0011 when addr[1]=0, else 1100; SW gives 1111; none gives 0000.
REQ-012 SHALL form store data by replication: SB gives {4{wdata[7:0]}}, SH gives {2{wdata[15:0]}}, SW gives wdata.
REQ-013 SHALL treat SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=00, as misaligned: no dm_we, no IO request, err=1 for that cycle, rdata=0.
REQ-014 SHALL drive dm_we = MemWrite and aligned and not IOWrite, combinationally, in any state.
REQ-015 SHALL give IOWrite priority when MemWrite and IOWrite are both high: dm_we=0 and the IO write proceeds.
REQ-016 SHALL extract the load source word from dm_rdata when state is IDLE, or from the latched IO word in DONE.
REQ-017 SHALL extend loads as follows: LB sign-extends byte addr[1:0]; LBU zero-extends it; LH sign-extends the halfword at addr[1]; LHU zero-extends it; LW passes the word; none gives 0.
REQ-018 SHALL implement the IO FSM states IDLE, REQ, and DONE.
REQ-019 SHALL, in IDLE with (IOWrite or IORead) and aligned, latch addr, lane enables, replicated data and the write flag into io_* registers, clear the counter, and go to REQ.
REQ-020 SHALL, in REQ, hold io_req=1 with io_* stable; on io_ack=1 it latches io_rdata and goes to DONE.
REQ-021 SHALL, in REQ, otherwise increment the counter; when counter==TIMEOUT-1 without ack, it latches 0 as the read word, pulses err in the DONE cycle, and goes to DONE.
REQ-022 SHALL, in DONE, drive io_req=0 and stall=0 and present rdata, then go unconditionally to IDLE, so a request still present in DONE is never re-issued.
REQ-023 SHALL drive stall = (IDLE and aligned IO request) or REQ, combinationally; IO latency is ack cycles + 2, and a memory access has 0 added latency.
REQ-024 SHALL ignore io_ack outside REQ.
REQ-025 SHALL reach DONE in the cycle after an io_ack that arrives in the first REQ cycle, giving a minimum IO access of 3 cycles.

Reset
REQ-026 SHALL, while reset=0, immediately force state=IDLE, io_req=0, io_we=0, io_addr/io_be/io_wdata=0, latched read word=0, counter=0 and err=0.
REQ-027 SHALL drop io_req asynchronously when reset asserts mid-REQ, and SHALL NOT issue a DONE cycle.
REQ-028 SHALL, after reset releases, take the first edge from IDLE.

Verification
REQ-029 SHALL cover: SB addr=0x1002, wdata=0x000000A5, MemWrite=1 -> dm_we=1, dm_be=0100, dm_wdata=0xA5A5A5A5, stall=0.
REQ-030 SHALL cover: LH addr=0x2002, dm_rdata=0x8001_7FFF -> rdata=0xFFFF8001; the same access as LHU -> 0x00008001.
REQ-031 SHALL cover: IORead LB addr=0x7F03, io_ack on the 3rd REQ cycle with io_rdata=0x80_000000 -> stall high 4 cycles, DONE rdata=0xFFFFFF80, io_req low in DONE.
REQ-032 SHALL cover: IOWrite SW, no ack, TIMEOUT=4 -> io_req high exactly 4 cycles, err pulse in DONE, rdata=0, then IDLE.
REQ-033 SHALL cover: SW addr=0x1006 -> dm_we=0, io_req=0, err=1 for one cycle; and MemWrite+IOWrite together -> dm_we=0, IO write issued.
REQ-034 SHALL cover: reset asserted in the 2nd REQ cycle -> io_req=0 the same cycle, state IDLE after release, no err.

Source files
------------

// File: rtl/mem_io_bridge.sv
// -----------------------------------------------------------------------------
// mem_io_bridge
//
// Purpose:
//   M-stage load/store bridge. Memory accesses go straight to a combinational
//   data memory with no added latency. IO accesses are run through a small
//   IDLE/REQ/DONE handshake FSM that stalls the pipeline until io_ack arrives
//   or the TIMEOUT budget runs out. Misaligned accesses are suppressed and
//   flagged on err.
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   addr, wdata       : M-stage byte address and store data
//   BeOP, MeOP        : store size (none/SB/SH/SW), load size (none/LB/LBU/LH/LHU/LW)
//   MemWrite          : memory store strobe
//   IOWrite, IORead   : IO store / IO load strobes
//   rdata             : extended load result
//   stall             : holds the M stage and everything upstream
//   dm_*              : data memory port (dm_rdata is a combinational read)
//   io_*              : IO request/acknowledge port
//   err               : one-cycle pulse on misaligned access or IO timeout
// -----------------------------------------------------------------------------
module mem_io_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  BeOP,
    input  logic [2:0]  MeOP,
    input  logic        MemWrite,
    input  logic        IOWrite,
    input  logic        IORead,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [3:0]  io_be,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic        err
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] lane_en(input logic [1:0] be_op, input logic [1:0] ofs);
        logic [3:0] en;
        case (be_op)
            2'b01:   en = 4'b0001 << ofs;
            2'b10:   en = ofs[1] ? 4'b1100 : 4'b0011;
            2'b11:   en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Store data replicated across lanes so any enabled lane sees the value.
    function automatic logic [31:0] store_data(input logic [1:0] be_op, input logic [31:0] wd);
        logic [31:0] d;
        case (be_op)
            2'b01:   d = {4{wd[7:0]}};
            2'b10:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic misaligned(input logic [1:0] be_op, input logic [2:0] me_op,
                                        input logic [1:0] ofs);
        logic is_half;
        logic is_word;
        is_half = (be_op == 2'b10) || (me_op == 3'b011) || (me_op == 3'b100);
        is_word = (be_op == 2'b11) || (me_op == 3'b101);
        return (is_half && ofs[0]) || (is_word && (ofs != 2'b00));
    endfunction

    // Select and sign/zero-extend the addressed byte or halfword of a word.
    function automatic logic [31:0] load_ext(input logic [2:0] me_op, input logic [1:0] ofs,
                                             input logic [31:0] src);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = src >> {ofs, 3'b000};
        b       = shifted[7:0];
        h       = ofs[1] ? src[31:16] : src[15:0];
        case (me_op)
            3'b001:  r = {{24{b[7]}}, b};
            3'b010:  r = {24'h000000, b};
            3'b011:  r = {{16{h[15]}}, h};
            3'b100:  r = {16'h0000, h};
            3'b101:  r = src;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   rd_word_r;
    logic          tmo_err_r;

    logic          mis_s;
    logic          io_go_s;
    logic [3:0]    be_s;
    logic [31:0]   wd_s;
    logic [31:0]   src_s;

    assign mis_s   = misaligned(BeOP, MeOP, addr[1:0]);
    assign io_go_s = (IOWrite | IORead) & ~mis_s;
    assign be_s    = lane_en(BeOP, addr[1:0]);
    assign wd_s    = store_data(BeOP, wdata);

    // Data memory port: purely combinational, IO store wins over memory store.
    always_comb begin
        dm_we    = MemWrite & ~mis_s & ~IOWrite;
        dm_be    = be_s;
        dm_addr  = {addr[31:2], 2'b00};
        dm_wdata = wd_s;
    end

    // Stall covers the issue cycle in IDLE and every REQ cycle, never DONE.
    always_comb begin
        if (state_r == ST_REQ) begin
            stall = 1'b1;
        end else if (state_r == ST_IDLE) begin
            stall = io_go_s;
        end else begin
            stall = 1'b0;
        end
    end

    // Load result: IO word in DONE, otherwise the memory word; zero if misaligned.
    always_comb begin
        if (state_r == ST_DONE) begin
            src_s = rd_word_r;
        end else begin
            src_s = dm_rdata;
        end
        if (mis_s) begin
            rdata = 32'h0000_0000;
        end else begin
            rdata = load_ext(MeOP, addr[1:0], src_s);
        end
    end

    // Error pulse: misalignment in the current cycle or a timeout seen in DONE.
    always_comb begin
        if (!reset) begin
            err = 1'b0;
        end else begin
            err = mis_s | tmo_err_r;
        end
    end

    // IO handshake FSM with registered request-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            rd_word_r <= 32'h0000_0000;
            tmo_err_r <= 1'b0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= 32'h0000_0000;
            io_be     <= 4'b0000;
            io_wdata  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tmo_err_r <= 1'b0;
                    if (io_go_s) begin
                        io_addr  <= addr;
                        io_be    <= be_s;
                        io_wdata <= wd_s;
                        io_we    <= IOWrite;
                        io_req   <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= ST_REQ;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (io_ack) begin
                        rd_word_r <= io_rdata;
                        io_req    <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Abort: an aborted read returns zero.
                        rd_word_r <= 32'h0000_0000;
                        tmo_err_r <= 1'b1;
                        io_req    <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r     <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    // Always return to IDLE so a request still held here is not re-issued.
                    tmo_err_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    tmo_err_r <= 1'b0;
                    io_req    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
